// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, valid/ack character delivery with parity/frame/overrun flags.
// Latency: data_valid rises the cycle after the final stop-bit sample (mid stop bit), 2-3 cycles of synchronizer delay on the pin.
// Backpressure: none on the line; an unacknowledged character is overwritten by the next one and overrun is flagged.
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   rx                                serial input, idle high
//   data_size, parity_en, parity_mode, stop_bit_size
//                                     frame format, latched at start-bit detection
//   data, data_valid, ack             received character and its handshake
//   parity_error, frame_error         status of the character in data
//   overrun                           sticky, cleared by ack
//   busy                              receiver is inside a frame
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       data_size,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       stop_bit_size,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       ack,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // synchronizer and edge detect
  logic       rx_meta, rx_s, rx_s_d;
  logic [1:0] sync_warm;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          cfg_size, cfg_size_n;
  logic          cfg_pen, cfg_pen_n;
  logic [1:0]    cfg_pm, cfg_pm_n;
  logic          cfg_stop2, cfg_stop2_n;
  logic          par_err_r, par_err_n;
  logic          stop_err_r, stop_err_n;

  logic [7:0] data_n;
  logic       data_valid_n, parity_error_n, frame_error_n, overrun_n;
  logic       tick;

  // The synchronizer resets to 1, so right after reset it still shows
  // stale "idle" values. sync_warm blocks start detection until rx_s_d
  // holds a real line sample, so a line that is already low after reset
  // does not look like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_d    <= 1'b1;
      sync_warm <= 2'd0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
      if (sync_warm != 2'd3) sync_warm <= sync_warm + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      cfg_size     <= 1'b0;
      cfg_pen      <= 1'b0;
      cfg_pm       <= 2'b00;
      cfg_stop2    <= 1'b0;
      par_err_r    <= 1'b0;
      stop_err_r   <= 1'b0;
      data         <= 8'h00;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_cnt      <= bit_cnt_n;
      shreg        <= shreg_n;
      cfg_size     <= cfg_size_n;
      cfg_pen      <= cfg_pen_n;
      cfg_pm       <= cfg_pm_n;
      cfg_stop2    <= cfg_stop2_n;
      par_err_r    <= par_err_n;
      stop_err_r   <= stop_err_n;
      data         <= data_n;
      data_valid   <= data_valid_n;
      parity_error <= parity_error_n;
      frame_error  <= frame_error_n;
      overrun      <= overrun_n;
    end
  end

  // cnt counts down to 0; the sample is taken on the edge where cnt is 0
  // and cnt is reloaded there, so sample points never drift.
  assign tick = (cnt == '0);
  assign busy = (state != S_IDLE);

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    bit_cnt_n      = bit_cnt;
    shreg_n        = shreg;
    cfg_size_n     = cfg_size;
    cfg_pen_n      = cfg_pen;
    cfg_pm_n       = cfg_pm;
    cfg_stop2_n    = cfg_stop2;
    par_err_n      = par_err_r;
    stop_err_n     = stop_err_r;
    data_n         = data;
    data_valid_n   = data_valid;
    parity_error_n = parity_error;
    frame_error_n  = frame_error;
    overrun_n      = overrun;

    if (data_valid && ack) begin
      data_valid_n = 1'b0;
      overrun_n    = 1'b0;
    end

    unique case (state)
      S_IDLE: begin
        if (sync_warm == 2'd3 && rx_s_d && !rx_s) begin
          state_n     = S_START;
          cnt_n       = CNT_HALF;
          bit_cnt_n   = 3'd0;
          cfg_size_n  = data_size;
          cfg_pen_n   = parity_en;
          cfg_pm_n    = parity_mode;
          cfg_stop2_n = stop_bit_size;
          par_err_n   = 1'b0;
          stop_err_n  = 1'b0;
        end
      end

      S_START: begin
        if (tick) begin
          cnt_n   = CNT_BIT;
          // a start bit that is high again at mid-bit was a glitch
          state_n = rx_s ? S_IDLE : S_DATA;
          if (rx_s) cnt_n = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      S_DATA: begin
        if (tick) begin
          cnt_n = CNT_BIT;
          if (bit_cnt == (cfg_size ? 3'd7 : 3'd6)) begin
            // 7-bit characters shift one place further so they land in [6:0]
            shreg_n   = cfg_size ? {rx_s, shreg[7:1]} : {1'b0, rx_s, shreg[7:2]};
            bit_cnt_n = 3'd0;
            state_n   = cfg_pen ? S_PARITY : S_STOP;
          end else begin
            shreg_n   = {rx_s, shreg[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      S_PARITY: begin
        if (tick) begin
          cnt_n     = CNT_BIT;
          // pm[1]=1: odd/even over the data; pm[1]=0: fixed mark/space bit
          par_err_n = rx_s ^ (cfg_pm[0] ^ (cfg_pm[1] & (^shreg)));
          state_n   = S_STOP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      S_STOP: begin
        if (tick) begin
          cnt_n = CNT_BIT;
          if (!rx_s) stop_err_n = 1'b1;
          if (bit_cnt == {2'b00, cfg_stop2}) begin
            // deliver at mid stop bit so an immediately following start edge is caught
            state_n        = S_IDLE;
            cnt_n          = '0;
            bit_cnt_n      = 3'd0;
            data_n         = shreg;
            parity_error_n = cfg_pen & par_err_r;
            frame_error_n  = stop_err_r | ~rx_s;
            data_valid_n   = 1'b1;
            if (data_valid && !ack) overrun_n = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Table of frames with hand-computed results, plus sequences for false start,
// overrun, ack on the completion edge and reset mid-frame.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       data_size = 1'b1;
  logic       parity_en = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic       stop_bit_size = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       data_valid, parity_error, frame_error, overrun, busy;

  int checks = 0;
  int errors = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_size(data_size), .parity_en(parity_en), .parity_mode(parity_mode),
    .stop_bit_size(stop_bit_size),
    .data(data), .data_valid(data_valid), .ack(ack),
    .parity_error(parity_error), .frame_error(frame_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       s8;
    logic       pen;
    logic [1:0] pm;
    logic       s2;
    logic       pbit;
    logic       slast;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
    int         exp_rise;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_bits(input logic [7:0] d, input logic s8, input logic pen,
                                          input logic pbit, input logic s2, input logic slast);
    logic [15:0] b;
    int idx;
    b = '1;
    b[0] = 1'b0;
    idx = 1;
    for (int i = 0; i < 8; i++) begin
      if (s8 || i < 7) begin
        b[idx] = d[i];
        idx++;
      end
    end
    if (pen) begin
      b[idx] = pbit;
      idx++;
    end
    if (s2) begin
      b[idx] = 1'b1;
      idx++;
    end
    b[idx] = slast;
    return b;
  endfunction

  // Drives one whole frame, one bit per CPB cycles, sampling after every edge.
  // Iteration n is sampled just after edge P0+n+1. Config is scrambled mid-frame
  // to show it is only used as latched at the start.
  task automatic drive_frame(input logic [7:0] d, input logic s8, input logic pen,
                             input logic [1:0] pm, input logic s2, input logic pbit,
                             input logic slast, input int ack_at,
                             output int dv_rise, output int busy_rise);
    logic [15:0] bits;
    int nb;
    logic prev_dv;
    bits = mk_bits(d, s8, pen, pbit, s2, slast);
    nb = 2 + (s8 ? 8 : 7) + int'(pen) + int'(s2);
    data_size = s8;
    parity_en = pen;
    parity_mode = pm;
    stop_bit_size = s2;
    dv_rise = -1;
    busy_rise = -1;
    prev_dv = data_valid;
    for (int n = 0; n < CPB * nb; n++) begin
      rx = bits[n / CPB];
      ack = (n == ack_at);
      if (n == 20) begin
        data_size = ~data_size;
        parity_en = ~parity_en;
        parity_mode = ~parity_mode;
        stop_bit_size = ~stop_bit_size;
      end
      @(posedge clk);
      #1;
      if (dv_rise < 0 && data_valid && !prev_dv) dv_rise = n;
      prev_dv = data_valid;
      if (busy_rise < 0 && busy) busy_rise = n;
    end
    ack = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack(input string name);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    chk({name, " ack clears valid"}, 32'(data_valid), 32'd0);
    chk({name, " ack clears overrun"}, 32'(overrun), 32'd0);
  endtask

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, brise, bfall;
    logic dv_seen, busy_seen;
    logic [15:0] bits;

    // d, s8, pen, pm, s2, pbit, slast, exp_d, exp_pe, exp_fe, dv rise iteration (16*nb-6)
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 154}; // 8N1
    tbl[1] = '{8'h53, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h53, 1'b1, 1'b0, 154}; // 7E1 bad parity
    tbl[2] = '{8'h53, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h53, 1'b0, 1'b0, 154}; // 7E1 good parity
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 186}; // 8O2, stop2 low
    tbl[4] = '{8'h2A, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, 170}; // 8M1 ok
    tbl[5] = '{8'h2A, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0, 170}; // 8S1 bad
    tbl[6] = '{8'h5A, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 154}; // 7O1 ok
    tbl[7] = '{8'hD5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 138}; // 7N1, bit7 dropped
    tbl[8] = '{8'hC3, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 186}; // 8E2 ok

    // reset state
    #23;
    chk("reset outputs", {24'd0, data}, 32'd0);
    chk("reset flags", {26'd0, data_valid, parity_error, frame_error, overrun, busy}, 32'd0);
    rst = 1'b1;
    idle(10);

    // table-driven frames
    for (int i = 0; i < 9; i++) begin
      drive_frame(tbl[i].d, tbl[i].s8, tbl[i].pen, tbl[i].pm, tbl[i].s2, tbl[i].pbit,
                  tbl[i].slast, -1, rise, brise);
      chk($sformatf("vec%0d data", i), 32'(data), 32'(tbl[i].exp_d));
      chk($sformatf("vec%0d parity_error", i), 32'(parity_error), 32'(tbl[i].exp_pe));
      chk($sformatf("vec%0d frame_error", i), 32'(frame_error), 32'(tbl[i].exp_fe));
      chk($sformatf("vec%0d valid", i), 32'(data_valid), 32'd1);
      chk($sformatf("vec%0d valid cycle", i), 32'(rise), 32'(tbl[i].exp_rise));
      if (i == 0) chk("busy rise cycle", 32'(brise), 32'd2);
      do_ack($sformatf("vec%0d", i));
      idle(20);
    end

    // false start: 5-cycle low pulse
    data_size = 1'b1; parity_en = 1'b0; parity_mode = 2'b00; stop_bit_size = 1'b0;
    brise = -1; bfall = -1; dv_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      rx = (n < 5) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (brise < 0 && busy) brise = n;
      if (brise >= 0 && bfall < 0 && !busy) bfall = n;
      if (data_valid) dv_seen = 1'b1;
    end
    chk("false start busy rise", 32'(brise), 32'd2);
    chk("false start busy fall", 32'(bfall), 32'd10);
    chk("false start no valid", 32'(dv_seen), 32'd0);
    drive_frame(8'h3C, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, -1, rise, brise);
    chk("after false start data", 32'(data), 32'h3C);
    chk("after false start valid cycle", 32'(rise), 32'd154);
    do_ack("after false start");
    idle(20);

    // overrun: two back-to-back frames, no ack
    drive_frame(8'h11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, -1, rise, brise);
    drive_frame(8'h22, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, -1, rise, brise);
    chk("overrun data", 32'(data), 32'h22);
    chk("overrun flag", 32'(overrun), 32'd1);
    chk("overrun valid", 32'(data_valid), 32'd1);
    do_ack("overrun");
    idle(20);

    // leave nonzero state behind, then reset in the 4th data bit
    drive_frame(8'h81, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, -1, rise, brise);
    idle(20);
    drive_frame(8'h81, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, -1, rise, brise);
    idle(20);
    chk("pre-reset flags", {27'd0, data_valid, frame_error, overrun, 2'b00}, {27'd0, 5'b11100});
    bits = mk_bits(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 4 * CPB + 8; n++) begin
      rx = bits[n / CPB];
      @(posedge clk);
      #1;
    end
    chk("mid-frame busy", 32'(busy), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("async reset data", 32'(data), 32'd0);
    chk("async reset flags", {27'd0, data_valid, parity_error, frame_error, overrun, busy}, 32'd0);
    rx = 1'b0;
    #3 rst = 1'b1;
    busy_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (busy) busy_seen = 1'b1;
    end
    chk("low line after reset is not a start", 32'(busy_seen), 32'd0);
    idle(30);
    drive_frame(8'h7E, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, -1, rise, brise);
    chk("post-reset data", 32'(data), 32'h7E);
    chk("post-reset valid cycle", 32'(rise), 32'd154);
    chk("post-reset errors", {30'd0, parity_error, frame_error}, 32'd0);
    do_ack("post-reset");
    idle(20);

    // ack landing on the completion edge of the overwriting frame
    drive_frame(8'h11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, -1, rise, brise);
    drive_frame(8'h22, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 154, rise, brise);
    chk("ack-on-completion data", 32'(data), 32'h22);
    chk("ack-on-completion valid", 32'(data_valid), 32'd1);
    chk("ack-on-completion overrun", 32'(overrun), 32'd0);
    do_ack("ack-on-completion");
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
